// File: rtl/bus_pkg.sv
// Shared definitions for the 8-bit CPU bus responders (SRAM, ROM, I/O).
package bus_pkg;

    localparam int BUS_ADDR_WIDTH  = 16;
    localparam int BUS_DATA_WIDTH  = 8;
    localparam int WAIT_STATES_MAX = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Wait counter needs at least one bit even with zero wait states.
    function automatic int cnt_width(input int wait_states);
        return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
    endfunction

endpackage

// File: rtl/sram_bus_responder_if.sv
// CPU bus request/response signals between the bus master and a responder.
interface sram_bus_responder_if
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH = BUS_DATA_WIDTH
);
    logic                  i_cs;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_dat;
    logic                  i_we;
    logic [DATA_WIDTH-1:0] o_dat;
    logic                  o_ack;

    modport master (
        output i_cs, i_addr, i_dat, i_we,
        input  o_dat, o_ack
    );

    modport slave (
        input  i_cs, i_addr, i_dat, i_we,
        output o_dat, o_ack
    );
endinterface

// File: rtl/wait_counter.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module wait_counter
    import bus_pkg::*;
#(
    parameter int WIDTH = cnt_width(WAIT_STATES_MAX)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/sram_bus_responder.sv
// CPU bus responder driving an asynchronous SRAM with WAIT_STATES extra access cycles.
//   state  | meaning
//   IDLE   | strobes off, waiting for i_cs
//   ACCESS | strobes active, counting wait states
//   ACK    | ack pulse; ce_n and write data still held for hold time
module sram_bus_responder
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH  = BUS_DATA_WIDTH,
    parameter int WAIT_STATES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    sram_bus_responder_if.slave   bus,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_dq,
    output logic                  o_sram_dq_oe,
    input  logic [DATA_WIDTH-1:0] i_sram_dq,
    output logic                  o_sram_ce_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n
);
    localparam int CNT_WIDTH = cnt_width(WAIT_STATES);

    state_t                r_state, w_state_nxt;
    logic                  r_ack, w_ack_nxt;
    logic [DATA_WIDTH-1:0] r_dat, w_dat_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdat, w_wdat_nxt;
    logic                  r_we, w_we_nxt;
    logic                  r_ce_n, w_ce_n_nxt;
    logic                  r_oe_n, w_oe_n_nxt;
    logic                  r_we_n, w_we_n_nxt;
    logic                  r_dq_oe, w_dq_oe_nxt;
    logic                  w_cnt_load, w_cnt_dec, w_cnt_zero;

    wait_counter #(.WIDTH(CNT_WIDTH)) u_wait_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_cnt_load),
        .i_load_val (CNT_WIDTH'(WAIT_STATES)),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_dat_nxt   = r_dat;
        w_addr_nxt  = r_addr;
        w_wdat_nxt  = r_wdat;
        w_we_nxt    = r_we;
        w_ce_n_nxt  = r_ce_n;
        w_oe_n_nxt  = r_oe_n;
        w_we_n_nxt  = r_we_n;
        w_dq_oe_nxt = r_dq_oe;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_cs) begin
                    w_addr_nxt  = bus.i_addr;
                    w_wdat_nxt  = bus.i_dat;
                    w_we_nxt    = bus.i_we;
                    w_cnt_load  = 1'b1;
                    w_ce_n_nxt  = 1'b0;
                    w_oe_n_nxt  = bus.i_we;
                    w_we_n_nxt  = !bus.i_we;
                    w_dq_oe_nxt = bus.i_we;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!w_cnt_zero) begin
                    w_cnt_dec = 1'b1;
                end else begin
                    if (!r_we) begin
                        w_dat_nxt = i_sram_dq;
                    end
                    // we_n rises here while dq_oe stays up one more cycle for data hold.
                    w_we_n_nxt  = 1'b1;
                    w_oe_n_nxt  = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_ce_n_nxt  = 1'b1;
                w_dq_oe_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_addr  <= '0;
            r_wdat  <= '0;
            r_we    <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_dat   <= w_dat_nxt;
            r_addr  <= w_addr_nxt;
            r_wdat  <= w_wdat_nxt;
            r_we    <= w_we_nxt;
            r_ce_n  <= w_ce_n_nxt;
            r_oe_n  <= w_oe_n_nxt;
            r_we_n  <= w_we_n_nxt;
            r_dq_oe <= w_dq_oe_nxt;
        end
    end

    assign bus.o_ack    = r_ack;
    assign bus.o_dat    = r_dat;
    assign o_sram_addr  = r_addr;
    assign o_sram_dq    = r_wdat;
    assign o_sram_dq_oe = r_dq_oe;
    assign o_sram_ce_n  = r_ce_n;
    assign o_sram_oe_n  = r_oe_n;
    assign o_sram_we_n  = r_we_n;
endmodule

// File: tb/tb_sram_bus_responder.sv
// Bench for sram_bus_responder at WAIT_STATES = 0, 1 and 15 against a simple SRAM model.
module tb_sram_bus_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs  = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdat = '0;
    logic        we  = 1'b0;
    int          sel = 0;   // 0: WAIT_STATES=0, 1: WAIT_STATES=1, 2: WAIT_STATES=15

    always #5 clk = ~clk;

    logic [15:0] s_addr  [3];
    logic [7:0]  s_dq    [3];
    logic [7:0]  s_dq_in [3];
    logic        s_dq_oe [3];
    logic        s_ce_n  [3];
    logic        s_oe_n  [3];
    logic        s_we_n  [3];

    sram_bus_responder_if bus0 ();
    sram_bus_responder_if bus1 ();
    sram_bus_responder_if bus2 ();

    assign bus0.i_cs = cs && (sel == 0);
    assign bus1.i_cs = cs && (sel == 1);
    assign bus2.i_cs = cs && (sel == 2);
    assign bus0.i_addr = addr;
    assign bus1.i_addr = addr;
    assign bus2.i_addr = addr;
    assign bus0.i_dat = wdat;
    assign bus1.i_dat = wdat;
    assign bus2.i_dat = wdat;
    assign bus0.i_we = we;
    assign bus1.i_we = we;
    assign bus2.i_we = we;

    function automatic logic [7:0] sram_model(input logic [15:0] a);
        case (a)
            16'h1234: return 8'hA5;
            16'h0001: return 8'h11;
            16'h0002: return 8'h22;
            16'h0005: return 8'h5A;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_sram
        assign s_dq_in[k] = sram_model(s_addr[k]);
    end

    sram_bus_responder #(.WAIT_STATES(0)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .bus(bus0.slave),
        .o_sram_addr(s_addr[0]), .o_sram_dq(s_dq[0]), .o_sram_dq_oe(s_dq_oe[0]),
        .i_sram_dq(s_dq_in[0]), .o_sram_ce_n(s_ce_n[0]), .o_sram_oe_n(s_oe_n[0]),
        .o_sram_we_n(s_we_n[0]));
    sram_bus_responder #(.WAIT_STATES(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .bus(bus1.slave),
        .o_sram_addr(s_addr[1]), .o_sram_dq(s_dq[1]), .o_sram_dq_oe(s_dq_oe[1]),
        .i_sram_dq(s_dq_in[1]), .o_sram_ce_n(s_ce_n[1]), .o_sram_oe_n(s_oe_n[1]),
        .o_sram_we_n(s_we_n[1]));
    sram_bus_responder #(.WAIT_STATES(15)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .bus(bus2.slave),
        .o_sram_addr(s_addr[2]), .o_sram_dq(s_dq[2]), .o_sram_dq_oe(s_dq_oe[2]),
        .i_sram_dq(s_dq_in[2]), .o_sram_ce_n(s_ce_n[2]), .o_sram_oe_n(s_oe_n[2]),
        .o_sram_we_n(s_we_n[2]));

    logic        o_ack;
    logic [7:0]  o_dat;
    always_comb begin
        case (sel)
            0:       begin o_ack = bus0.o_ack; o_dat = bus0.o_dat; end
            1:       begin o_ack = bus1.o_ack; o_dat = bus1.o_dat; end
            default: begin o_ack = bus2.o_ack; o_dat = bus2.o_dat; end
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected o_dat per request, observed o_dat and ack cycle per ack pulse.
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];
    int         ack_cyc_q [$];
    logic [7:0] exp_dat [3] = '{8'h00, 8'h00, 8'h00};

    int          oe_low, we_low, ce_low, dqoe_hi, addr_dev;
    logic [15:0] wr_addr;
    logic [7:0]  wr_dq;

    task automatic observe(input int ncyc, input int chg_cyc, input logic chg_cs,
                           input logic [15:0] chg_addr, input int drop_cyc,
                           input logic [15:0] want_addr);
        oe_low = 0; we_low = 0; ce_low = 0; dqoe_hi = 0; addr_dev = 0;
        wr_addr = '0; wr_dq = '0;
        obs_q.delete();
        ack_cyc_q.delete();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (o_ack) begin
                ack_cyc_q.push_back(c);
                obs_q.push_back(o_dat);
            end
            if (!s_oe_n[sel]) oe_low++;
            if (!s_ce_n[sel]) ce_low++;
            if (s_dq_oe[sel]) dqoe_hi++;
            if (!s_we_n[sel]) begin
                we_low++;
                wr_addr = s_addr[sel];
                wr_dq   = s_dq[sel];
            end
            if (!s_ce_n[sel] && s_addr[sel] != want_addr) addr_dev++;
            if (c == chg_cyc) begin
                cs   = chg_cs;
                addr = chg_addr;
            end
            if (c == drop_cyc) cs = 1'b0;
        end
    endtask

    task automatic request(input int s, input logic w, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        sel  = s;
        we   = w;
        addr = a;
        wdat = d;
        cs   = 1'b1;
        if (!w) exp_dat[s] = sram_model(a);
        exp_q.push_back(exp_dat[s]);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_checks++;
            if ({o_ack, o_dat, s_ce_n[s], s_oe_n[s], s_we_n[s], s_dq_oe[s], s_addr[s], s_dq[s]}
                !== {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00}) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: ack=%b dat=%h ce_n=%b oe_n=%b we_n=%b dq_oe=%b addr=%h dq=%h",
                         s, o_ack, o_dat, s_ce_n[s], s_oe_n[s], s_we_n[s], s_dq_oe[s], s_addr[s], s_dq[s]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        request(1, 1'b1, 16'h0033, 8'h99);
        void'(exp_q.pop_back());
        @(negedge clk);
        n_checks++;
        if (s_we_n[1] !== 1'b0 || s_dq_oe[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_write_setup: we_n=%b dq_oe=%b, want 0/1", s_we_n[1], s_dq_oe[1]);
        end
        #1 rst = 1'b1;
        cs = 1'b0;
        #1;
        n_checks++;
        if ({s_we_n[1], s_ce_n[1], s_dq_oe[1]} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_async_strobes: we_n,ce_n,dq_oe=%b want 110",
                     {s_we_n[1], s_ce_n[1], s_dq_oe[1]});
        end
        @(negedge clk);
        rst = 1'b0;
        observe(6, 0, 1'b0, 16'h0000, 0, 16'h0000);
        n_checks++;
        if (ack_cyc_q.size() != 0 || ce_low != 0) begin
            n_fail++;
            $display("FAIL reset_no_ack: acks=%0d ce_low=%0d, want 0/0", ack_cyc_q.size(), ce_low);
        end
    endtask

    task automatic test_read_ws1;
        request(1, 1'b0, 16'h1234, 8'h00);
        observe(8, 1, 1'b0, 16'h1234, 0, 16'h1234);
        n_checks++;
        if (ack_cyc_q.size() != 1 || ack_cyc_q[0] != 3) begin
            n_fail++;
            $display("FAIL read_ws1_ack: acks=%0d first_cycle=%0d, want 1 at 3",
                     ack_cyc_q.size(), (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1);
        end
        n_checks++;
        if (oe_low != 2 || ce_low != 3 || we_low != 0 || dqoe_hi != 0 || addr_dev != 0) begin
            n_fail++;
            $display("FAIL read_ws1_strobes: oe_low=%0d ce_low=%0d we_low=%0d dq_oe=%0d addr_dev=%0d, want 2/3/0/0/0",
                     oe_low, ce_low, we_low, dqoe_hi, addr_dev);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL read_ws1_data: o_dat=%h want %h", o, e);
            end
        end
        n_checks++;
        if (o_dat !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_ws1_hold: o_dat=%h want a5", o_dat);
        end
    endtask

    task automatic test_write_ws0;
        request(0, 1'b0, 16'h0005, 8'h00);
        observe(4, 1, 1'b0, 16'h0005, 0, 16'h0005);
        n_checks++;
        if (ack_cyc_q.size() != 1 || ack_cyc_q[0] != 2 || oe_low != 1) begin
            n_fail++;
            $display("FAIL read_ws0_timing: acks=%0d oe_low=%0d, want 1 ack at 2, oe_low 1",
                     ack_cyc_q.size(), oe_low);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL read_ws0_data: o_dat=%h want %h", o, e);
            end
        end
        request(0, 1'b1, 16'h00FF, 8'h3C);
        observe(5, 1, 1'b0, 16'h00FF, 0, 16'h00FF);
        n_checks++;
        if (ack_cyc_q.size() != 1 || ack_cyc_q[0] != 2) begin
            n_fail++;
            $display("FAIL write_ws0_ack: acks=%0d first_cycle=%0d, want 1 at 2",
                     ack_cyc_q.size(), (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1);
        end
        n_checks++;
        if (we_low != 1 || dqoe_hi != 2 || oe_low != 0 || ce_low != 2) begin
            n_fail++;
            $display("FAIL write_ws0_strobes: we_low=%0d dq_oe=%0d oe_low=%0d ce_low=%0d, want 1/2/0/2",
                     we_low, dqoe_hi, oe_low, ce_low);
        end
        n_checks++;
        if (wr_addr !== 16'h00FF || wr_dq !== 8'h3C) begin
            n_fail++;
            $display("FAIL write_ws0_bus: addr=%h dq=%h want 00ff/3c", wr_addr, wr_dq);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL write_ws0_dat_kept: o_dat=%h want %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        request(1, 1'b0, 16'h0001, 8'h00);
        exp_dat[1] = sram_model(16'h0002);
        exp_q.push_back(exp_dat[1]);
        observe(10, 4, 1'b1, 16'h0002, 5, 16'h0000);
        n_checks++;
        if (ack_cyc_q.size() != 2 || ack_cyc_q[0] != 3 || ack_cyc_q[1] != 7) begin
            n_fail++;
            $display("FAIL b2b_ack_cycles: acks=%0d, want 2 at cycles 3 and 7", ack_cyc_q.size());
        end
        n_checks++;
        if (ce_low != 6 || oe_low != 4) begin
            n_fail++;
            $display("FAIL b2b_strobes: ce_low=%0d oe_low=%0d, want 6/4", ce_low, oe_low);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_data: o_dat=%h want %h", o, e);
            end
        end
    endtask

    task automatic test_abandoned;
        request(1, 1'b0, 16'h0010, 8'h00);
        observe(8, 1, 1'b0, 16'hBEEF, 0, 16'h0010);
        n_checks++;
        if (ack_cyc_q.size() != 1 || addr_dev != 0 || s_addr[1] === 16'hBEEF) begin
            n_fail++;
            $display("FAIL abandoned: acks=%0d addr_dev=%0d sram_addr=%h, want 1/0/0010",
                     ack_cyc_q.size(), addr_dev, s_addr[1]);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abandoned_data: o_dat=%h want %h", o, e);
            end
        end
    endtask

    task automatic test_ws15;
        request(2, 1'b0, 16'h4321, 8'h00);
        observe(22, 5, 1'b1, 16'h0000, 6, 16'h4321);
        n_checks++;
        if (ack_cyc_q.size() != 1 || ack_cyc_q[0] != 17) begin
            n_fail++;
            $display("FAIL ws15_ack: acks=%0d first_cycle=%0d, want 1 at 17",
                     ack_cyc_q.size(), (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1);
        end
        n_checks++;
        if (oe_low != 16 || ce_low != 17 || addr_dev != 0) begin
            n_fail++;
            $display("FAIL ws15_strobes: oe_low=%0d ce_low=%0d addr_dev=%0d, want 16/17/0",
                     oe_low, ce_low, addr_dev);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ws15_data: o_dat=%h want %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_read_ws1();
        test_write_ws0();
        test_back_to_back();
        test_abandoned();
        test_ws15();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected results never observed", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
